// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder
//   Serialises packet bytes LSB-first on the clk12 bit strobe, applies bit
//   stuffing and NRZI, drives the full-speed D+/D- pair and closes each packet
//   with EOP (SE0 x EOP_SE0_BITS, then J). SYNC is supplied upstream as data.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | line held at J, waiting for tx_start with a valid byte
//   SHIFT   | each strobe drives shift_q[0]; byte reload at bit 7
//   STUFF   | next strobe drives a stuffed 0 (line toggle)
//   EOP_SE0 | each strobe drives SE0, down-counting the SE0 bit times
//   EOP_J   | next strobe drives J and returns to IDLE
//
// Ports
//   clk, n_rst          clock, synchronous active-low reset
//   bit_strobe          one-cycle bit-time strobe
//   tx_start            packet request, honoured only in IDLE
//   tx_data/tx_last     byte and final-byte flag, qualified by tx_data_valid
//   tx_data_ready       one-cycle accept pulse
//   dp_out/dm_out       differential line
//   serial_out          raw pre-NRZI bit (0 on stuff and SE0 bits)
//   stuff_active        high during a stuffed bit time
//   tx_busy             byte accept through EOP completion
//   tx_done/tx_error    completion / underrun pulses
module usb_tx_encoder #(
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       bit_strobe,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       dp_out,
    output logic       dm_out,
    output logic       serial_out,
    output logic       stuff_active,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    typedef enum logic [2:0] {IDLE, SHIFT, STUFF, EOP_SE0, EOP_J} state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [2:0] ones_q, ones_d;
    logic [1:0] se0_cnt_q, se0_cnt_d;
    logic       last_q, last_d;
    logic       fin_q, fin_d;      // last byte fully shifted, only a stuff bit may remain
    logic       err_q, err_d;      // packet ended by underrun, suppresses tx_done
    logic       lvl_q, lvl_d;      // NRZI level, 1 = J
    logic       ready_q, ready_d;
    logic       dp_q, dp_d;
    logic       dm_q, dm_d;
    logic       serial_q, serial_d;
    logic       stuff_q, stuff_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    logic [3:0] ones_inc;
    logic       stuff_due;
    logic       lvl_nrzi;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        ones_d    = ones_q;
        se0_cnt_d = se0_cnt_q;
        last_d    = last_q;
        fin_d     = fin_q;
        err_d     = err_q;
        lvl_d     = lvl_q;
        ready_d   = 1'b0;
        dp_d      = dp_q;
        dm_d      = dm_q;
        serial_d  = serial_q;
        stuff_d   = stuff_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        ones_inc  = {1'b0, ones_q} + 4'd1;
        stuff_due = shift_q[0] && (ones_inc == 4'(STUFF_LEN));
        // a raw 0 toggles the line, a raw 1 holds it
        lvl_nrzi  = lvl_q ^ ~shift_q[0];

        case (state_q)
            IDLE: begin
                dp_d     = 1'b1;
                dm_d     = 1'b0;
                serial_d = 1'b1;
                stuff_d  = 1'b0;
                lvl_d    = 1'b1;
                if (tx_start && tx_data_valid) begin
                    shift_d   = tx_data;
                    last_d    = tx_last;
                    ready_d   = 1'b1;
                    busy_d    = 1'b1;
                    bit_idx_d = 3'd0;
                    ones_d    = 3'd0;
                    fin_d     = 1'b0;
                    err_d     = 1'b0;
                    se0_cnt_d = 2'(EOP_SE0_BITS);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_strobe) begin
                    serial_d  = shift_q[0];
                    stuff_d   = 1'b0;
                    lvl_d     = lvl_nrzi;
                    dp_d      = lvl_nrzi;
                    dm_d      = ~lvl_nrzi;
                    ones_d    = shift_q[0] ? ones_inc[2:0] : 3'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    state_d   = stuff_due ? STUFF : SHIFT;
                    if (bit_idx_q == 3'd7) begin
                        if (last_q) begin
                            fin_d = 1'b1;
                            if (!stuff_due) state_d = EOP_SE0;
                        end else if (tx_data_valid) begin
                            // reload even with a stuff bit pending; ones carry over
                            shift_d = tx_data;
                            last_d  = tx_last;
                            ready_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                            err_d   = 1'b1;
                            state_d = EOP_SE0;
                        end
                    end
                end
            end
            STUFF: begin
                if (bit_strobe) begin
                    lvl_d    = ~lvl_q;
                    dp_d     = ~lvl_q;
                    dm_d     = lvl_q;
                    serial_d = 1'b0;
                    stuff_d  = 1'b1;
                    ones_d   = 3'd0;
                    state_d  = fin_q ? EOP_SE0 : SHIFT;
                end
            end
            EOP_SE0: begin
                if (bit_strobe) begin
                    dp_d      = 1'b0;
                    dm_d      = 1'b0;
                    serial_d  = 1'b0;
                    stuff_d   = 1'b0;
                    se0_cnt_d = se0_cnt_q - 2'd1;
                    if (se0_cnt_q == 2'd1) state_d = EOP_J;
                end
            end
            EOP_J: begin
                if (bit_strobe) begin
                    dp_d     = 1'b1;
                    dm_d     = 1'b0;
                    serial_d = 1'b1;
                    lvl_d    = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = ~err_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            ones_q    <= 3'd0;
            se0_cnt_q <= 2'd0;
            last_q    <= 1'b0;
            fin_q     <= 1'b0;
            err_q     <= 1'b0;
            lvl_q     <= 1'b1;
            ready_q   <= 1'b0;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
            serial_q  <= 1'b1;
            stuff_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            ones_q    <= ones_d;
            se0_cnt_q <= se0_cnt_d;
            last_q    <= last_d;
            fin_q     <= fin_d;
            err_q     <= err_d;
            lvl_q     <= lvl_d;
            ready_q   <= ready_d;
            dp_q      <= dp_d;
            dm_q      <= dm_d;
            serial_q  <= serial_d;
            stuff_q   <= stuff_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign tx_data_ready = ready_q;
    assign dp_out        = dp_q;
    assign dm_out        = dm_q;
    assign serial_out    = serial_q;
    assign stuff_active  = stuff_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign tx_error      = error_q;

endmodule
